fetch_prefetch_unit: RTL and testbench
======================================

FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

Interface
REQ-001 SHALL have parameter Widht, default 32, address/PC width in bits.
REQ-002 SHALL have parameter ResetPC, default 0, first fetch address after reset.
REQ-003 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port Stall  input  1  downstream pipeline register cannot accept an instruction this cycle.
REQ-006 SHALL have port Redirect  input  1  branch/jump taken; refetch from RedirectPC.
REQ-007 SHALL have port RedirectPC  input  Widht  redirect target address.
REQ-008 SHALL have port MemReq  output  1  instruction memory read request.
REQ-009 SHALL have port MemAddr  output  Widht  address of the pending read.
REQ-010 SHALL have port MemAck  input  1  read complete; MemData valid this cycle.
REQ-011 SHALL have port MemData  input  32  instruction word returned by memory.
REQ-012 SHALL have port InstrValid  output  1  InstrOut/PCOut hold a valid instruction.
REQ-013 SHALL have port InstrOut  output  32  instruction word to the downstream pipeline register.
REQ-014 SHALL have port PCOut  output  Widht  address of InstrOut.

Function
REQ-015 SHALL contain a 2-entry prefetch FIFO of {instruction, PC} pairs, a fetch PC register, an entry count (0..2), and a 3-state FSM: IDLE, WAIT, DROP.
REQ-016 SHALL drive MemReq = 1 exactly when the FSM is in WAIT or DROP; MemAddr SHALL be held constant while MemReq = 1 until MemAck = 1.
REQ-017 A transaction SHALL complete in any cycle with MemReq = 1 and MemAck = 1; MemAck while MemReq = 0 SHALL be ignored.
REQ-018 IDLE -> WAIT when count + pops-this-cycle leaves at least one free entry; MemAddr <= fetch PC.
REQ-019 WAIT, MemAck = 1: push {MemData, MemAddr}, fetch PC <= MemAddr + 4 (modulo 2^Widht); stay in WAIT with MemAddr <= new fetch PC if an entry is still free after the push and any same-cycle pop, else go to IDLE.
REQ-020 DROP, MemAck = 1: discard MemData, no push; go to IDLE.
REQ-021 The FIFO SHALL never overflow: no request is issued unless (count - pop + outstanding) < 2.
REQ-022 InstrValid SHALL be 1 whenever count > 0; InstrOut/PCOut SHALL show the FIFO head, combinationally from FIFO storage.
REQ-023 Pop SHALL occur when InstrValid = 1 and Stall = 0 and Redirect = 0; a push and a pop in the same cycle SHALL leave count unchanged and keep order.
REQ-024 Redirect = 1 SHALL take priority over push, pop and Stall in that cycle: FIFO flushed (count <= 0), fetch PC <= RedirectPC; WAIT -> DROP, DROP stays DROP, IDLE stays IDLE (new request from next cycle).
REQ-025 Redirect with MemAck in the same cycle SHALL discard the returning word and go to IDLE.
REQ-026 Stall = 1 SHALL hold InstrOut/PCOut/InstrValid stable; prefetching continues until the FIFO is full.
REQ-027 PC increment SHALL wrap from 2^Widht - 4 to 0 with no error indication.
REQ-028 Latency: with MemAck returned the cycle after MemReq rises, first InstrValid SHALL appear 2 cycles after the request cycle; sustained throughput 1 instruction per cycle when Stall = 0.

Reset
REQ-029 Reset = 1 at a rising edge SHALL set FSM = IDLE, count = 0, fetch PC = ResetPC, MemAddr = ResetPC; hence MemReq = 0, InstrValid = 0.
REQ-030 InstrOut and PCOut SHALL read 0 while count = 0 after reset.
REQ-031 Reset SHALL override Redirect, MemAck and Stall; reset mid-transaction abandons the pending read, and the memory SHALL treat MemReq falling as cancellation.
REQ-032 First request after reset SHALL be issued at address ResetPC in the cycle after Reset deasserts.

Verification
REQ-033 Reset, ResetPC = 0, memory acks 1 cycle after each request, Stall = 0 -> PCOut sequence 0x0, 0x4, 0x8, ... with InstrValid continuous after the first word.
REQ-034 Stall = 1 held for 10 cycles -> exactly 2 entries buffered, MemReq = 0 after the FIFO fills, InstrOut unchanged; release -> PCs resume in order with no gap or duplicate.
REQ-035 Redirect to 0x100 while a read of 0x8 is outstanding -> FSM DROP, word for 0x8 discarded, next MemAddr = 0x100, next valid PCOut = 0x100.
REQ-036 Redirect to 0x40 in the same cycle as MemAck -> word discarded, FIFO empty, next request at 0x40.
REQ-037 Fetch PC = 0xFFFFFFFC -> next PCOut = 0x00000000.
REQ-038 Reset asserted while MemReq = 1 and count = 2 -> next cycle MemReq = 0, InstrValid = 0, MemAddr = ResetPC.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: one outstanding memory read feeding a
// 2-entry {instruction, PC} prefetch FIFO, with redirect flush and drop.
module fetch_prefetch_unit #(
  parameter int               Widht   = 32,
  parameter logic [Widht-1:0] ResetPC = '0
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Redirect,
  input  logic [Widht-1:0] RedirectPC,
  output logic             MemReq,
  output logic [Widht-1:0] MemAddr,
  input  logic             MemAck,
  input  logic [31:0]      MemData,
  output logic             InstrValid,
  output logic [31:0]      InstrOut,
  output logic [Widht-1:0] PCOut,
  output logic [1:0]       DbgState
);

  // Handshakes: a memory read completes in any cycle with MemReq=1 and
  // MemAck=1; the downstream consumes the head in any cycle with
  // InstrValid=1, Stall=0 and Redirect=0.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       count_q, count_d;
  logic [Widht-1:0] fetch_pc_q, fetch_pc_d;
  logic [Widht-1:0] addr_q, addr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [31:0]      instr_mem_q [2];
  logic [Widht-1:0] pc_mem_q [2];

  logic             push;
  logic             pop;
  logic [1:0]       count_less_pop;
  logic [Widht-1:0] next_pc;

  always_comb begin
    pop            = (count_q != 2'd0) && !Stall && !Redirect;
    push           = (state_q == S_WAIT) && MemAck && !Redirect;
    count_less_pop = count_q - {1'b0, pop};
    next_pc        = addr_q + Widht'(4);

    state_d    = state_q;
    count_d    = count_less_pop + {1'b0, push};
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    rd_ptr_d   = rd_ptr_q ^ pop;
    wr_ptr_d   = wr_ptr_q ^ push;

    if (Redirect) begin
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      fetch_pc_d = RedirectPC;
    end

    case (state_q)
      S_IDLE: begin
        if (!Redirect && (count_less_pop < 2'd2)) begin
          state_d = S_WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      S_WAIT: begin
        // An unacked read under redirect must still be drained, hence DROP.
        if (Redirect) begin
          state_d = MemAck ? S_IDLE : S_DROP;
        end else if (MemAck) begin
          fetch_pc_d = next_pc;
          if (count_less_pop == 2'd0) begin
            addr_d = next_pc;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (MemAck) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      count_q        <= 2'd0;
      fetch_pc_q     <= ResetPC;
      addr_q         <= ResetPC;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      instr_mem_q[0] <= '0;
      instr_mem_q[1] <= '0;
      pc_mem_q[0]    <= '0;
      pc_mem_q[1]    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
        instr_mem_q[wr_ptr_q] <= MemData;
        pc_mem_q[wr_ptr_q]    <= addr_q;
      end
    end
  end

  assign MemReq     = (state_q == S_WAIT) || (state_q == S_DROP);
  assign MemAddr    = addr_q;
  assign InstrValid = (count_q != 2'd0);
  assign InstrOut   = instr_mem_q[rd_ptr_q];
  assign PCOut      = pc_mem_q[rd_ptr_q];
  assign DbgState   = state_q;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: cycle vector table after reset, stall,
// redirect, wrap and reset corner sequences, random traffic with a PC scoreboard.
module tb_fetch_prefetch_unit;

  logic        CLK;
  logic        Reset;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemData;
  logic        InstrValid;
  logic [31:0] InstrOut;
  logic [31:0] PCOut;
  logic [1:0]  DbgState;

  logic        ack_en;
  logic        req_seen;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] next_exp;
  logic        prev_hold;
  logic [31:0] prev_addr;
  logic [31:0] last_pop_pc;
  logic        saw_wrap;
  int          pops;

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic        chk_pc;
    logic [31:0] pc;
  } vec_t;
  vec_t vec [12];

  fetch_prefetch_unit #(.Widht(32), .ResetPC(32'h0)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .MemReq     (MemReq),
    .MemAddr    (MemAddr),
    .MemAck     (MemAck),
    .MemData    (MemData),
    .InstrValid (InstrValid),
    .InstrOut   (InstrOut),
    .PCOut      (PCOut),
    .DbgState   (DbgState)
  );

  // ---------------- clock / memory model ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // Pipelined memory: answers one cycle after the request is first seen.
  always @(posedge CLK) req_seen <= MemReq;
  assign MemAck  = MemReq & req_seen & ack_en;
  assign MemData = mem_word(MemAddr);

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic expect_seq(input logic [31:0] start);
    exp_q.delete();
    next_exp = start;
    repeat (8) begin
      exp_q.push_back(next_exp);
      next_exp = next_exp + 32'd4;
    end
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input logic ack);
    Stall      = st;
    Redirect   = rd;
    RedirectPC = rpc;
    ack_en     = ack;
    if (rd) expect_seq(rpc);
    #1;
  endtask

  task automatic sb_check();
    logic [31:0] e;
    if (prev_hold && MemReq) check("memaddr_hold", MemAddr, prev_addr);
    if (InstrValid && !Stall && !Redirect) begin
      while (exp_q.size() < 4) begin
        exp_q.push_back(next_exp);
        next_exp = next_exp + 32'd4;
      end
      e = exp_q.pop_front();
      check("sb_pc", PCOut, e);
      check("sb_instr", InstrOut, mem_word(e));
      if (pops > 0 && last_pop_pc == 32'hFFFF_FFFC && PCOut == 32'h0) saw_wrap = 1'b1;
      last_pop_pc = PCOut;
      pops++;
    end
    prev_hold = MemReq && !MemAck;
    prev_addr = MemAddr;
  endtask

  task automatic finish_cycle();
    sb_check();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    Stall    = 1'b0;
    Redirect = 1'b0;
    ack_en   = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    Reset     = 1'b0;
    prev_hold = 1'b0;
    pops      = 0;
    expect_seq(32'h0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] cap_pc;
    logic [31:0] cap_instr;
    logic        found;
    logic        st;
    logic        ack;

    //            stall req   addr    valid chk   pc
    vec[0]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h00};
    vec[1]  = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b1, 32'h00};
    vec[2]  = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b1, 32'h00};
    vec[3]  = '{1'b0, 1'b1, 32'h04, 1'b1, 1'b1, 32'h00};
    vec[4]  = '{1'b1, 1'b1, 32'h08, 1'b1, 1'b1, 32'h04};
    vec[5]  = '{1'b1, 1'b0, 32'h08, 1'b1, 1'b1, 32'h04};
    vec[6]  = '{1'b1, 1'b0, 32'h08, 1'b1, 1'b1, 32'h04};
    vec[7]  = '{1'b0, 1'b0, 32'h08, 1'b1, 1'b1, 32'h04};
    vec[8]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 1'b1, 32'h08};
    vec[9]  = '{1'b0, 1'b1, 32'h0C, 1'b0, 1'b0, 32'h00};
    vec[10] = '{1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h0C};
    vec[11] = '{1'b0, 1'b1, 32'h14, 1'b1, 1'b1, 32'h10};

    RedirectPC = 32'h0;
    saw_wrap   = 1'b0;
    last_pop_pc = 32'h0;
    do_reset();
    check("reset_state", {30'd0, DbgState}, 32'd0);

    // Cycle-by-cycle from reset: latency, stall fill, resume.
    for (int i = 0; i < 12; i++) begin
      drive(vec[i].stall, 1'b0, 32'h0, 1'b1);
      check($sformatf("vec%0d_req", i), {31'd0, MemReq}, {31'd0, vec[i].req});
      check($sformatf("vec%0d_addr", i), MemAddr, vec[i].addr);
      check($sformatf("vec%0d_valid", i), {31'd0, InstrValid}, {31'd0, vec[i].valid});
      if (vec[i].chk_pc) begin
        check($sformatf("vec%0d_pc", i), PCOut, vec[i].pc);
        check($sformatf("vec%0d_instr", i), InstrOut, vec[i].valid ? mem_word(vec[i].pc) : 32'h0);
      end
      finish_cycle();
    end

    // Long stall: buffer fills to two, request stops, head stays put.
    cap_pc    = PCOut;
    cap_instr = InstrOut;
    check("stall_start_valid", {31'd0, InstrValid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      check("stall_pc", PCOut, cap_pc);
      check("stall_instr", InstrOut, cap_instr);
      check("stall_valid", {31'd0, InstrValid}, 32'd1);
      finish_cycle();
    end
    check("stall_memreq", {31'd0, MemReq}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    finish_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("release_2nd_valid", {31'd0, InstrValid}, 32'd1);
    check("release_2nd_pc", PCOut, cap_pc + 32'd4);
    finish_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("release_3rd_empty", {31'd0, InstrValid}, 32'd0);
    finish_cycle();
    repeat (10) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      finish_cycle();
    end

    // Redirect while the read of 0x8 is outstanding.
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (MemReq && MemAddr == 32'h8) begin
        drive(1'b0, 1'b1, 32'h100, 1'b0);
        found = 1'b1;
      end
      finish_cycle();
    end
    if (!found) timeout("wait_addr8");
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("drop_state", {30'd0, DbgState}, 32'd2);
    check("drop_addr", MemAddr, 32'h8);
    check("drop_valid", {31'd0, InstrValid}, 32'd0);
    finish_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("drop_done_req", {31'd0, MemReq}, 32'd0);
    check("drop_done_valid", {31'd0, InstrValid}, 32'd0);
    finish_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("redir_req", {31'd0, MemReq}, 32'd1);
    check("redir_addr", MemAddr, 32'h100);
    finish_cycle();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (InstrValid) begin
        found = 1'b1;
        check("redir_first_pc", PCOut, 32'h100);
      end
      finish_cycle();
    end
    if (!found) timeout("wait_valid_100");

    // Redirect in the same cycle as MemAck.
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (MemReq && MemAck) begin
        drive(1'b0, 1'b1, 32'h40, 1'b1);
        found = 1'b1;
      end
      finish_cycle();
    end
    if (!found) timeout("wait_ack");
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("ackredir_state", {30'd0, DbgState}, 32'd0);
    check("ackredir_req", {31'd0, MemReq}, 32'd0);
    check("ackredir_valid", {31'd0, InstrValid}, 32'd0);
    finish_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("ackredir_next_addr", MemAddr, 32'h40);
    check("ackredir_next_req", {31'd0, MemReq}, 32'd1);
    finish_cycle();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (InstrValid) begin
        found = 1'b1;
        check("ackredir_first_pc", PCOut, 32'h40);
      end
      finish_cycle();
    end
    if (!found) timeout("wait_valid_40");

    // Address wrap at the top of the space.
    saw_wrap = 1'b0;
    drive(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    finish_cycle();
    repeat (12) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      finish_cycle();
    end
    check("pc_wrap_seen", {31'd0, saw_wrap}, 32'd1);

    // Random stall / ack / redirect traffic against the PC scoreboard.
    repeat (300) begin
      st  = ($urandom_range(0, 2) == 0);
      ack = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 24) == 0) drive(st, 1'b1, $urandom_range(0, 1023) << 2, ack);
      else drive(st, 1'b0, 32'h0, ack);
      finish_cycle();
    end

    // Reset mid-transaction overrides redirect, stall and ack.
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    finish_cycle();
    repeat (4) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      finish_cycle();
    end
    Reset = 1'b1;
    drive(1'b1, 1'b1, 32'h200, 1'b1);
    check("prereset_req", {31'd0, MemReq}, 32'd1);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    prev_hold = 1'b0;
    expect_seq(32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("midreset_req", {31'd0, MemReq}, 32'd0);
    check("midreset_valid", {31'd0, InstrValid}, 32'd0);
    check("midreset_addr", MemAddr, 32'h0);
    check("midreset_pc", PCOut, 32'h0);
    check("midreset_instr", InstrOut, 32'h0);
    finish_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("postreset_req", {31'd0, MemReq}, 32'd1);
    check("postreset_addr", MemAddr, 32'h0);
    finish_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
